// File: rtl/multicycle_ctrl_fsm_pkg.sv
// ctrl_pkg: shared types and encodings for the multi-cycle RV32I controller.
// The datapath muxes use the same ResultSrc/ALUSrcA/ALUSrcB/ALUOp encodings.
package ctrl_pkg;

    localparam int unsigned OPCODE_WIDTH = 7;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal,
        StJalr,
        StLui,
        StTrap
    } state_e;

    localparam logic [OPCODE_WIDTH-1:0] OpLoad   = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OpStore  = 7'b0100011;
    localparam logic [OPCODE_WIDTH-1:0] OpRType  = 7'b0110011;
    localparam logic [OPCODE_WIDTH-1:0] OpIType  = 7'b0010011;
    localparam logic [OPCODE_WIDTH-1:0] OpBranch = 7'b1100011;
    localparam logic [OPCODE_WIDTH-1:0] OpJal    = 7'b1101111;
    localparam logic [OPCODE_WIDTH-1:0] OpJalr   = 7'b1100111;
    localparam logic [OPCODE_WIDTH-1:0] OpLui    = 7'b0110111;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;
    localparam logic [1:0] ResImmExt    = 2'b11;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2   = 2'b00;
    localparam logic [1:0] SrcBImm   = 2'b01;
    localparam logic [1:0] SrcBFour  = 2'b10;

    localparam logic [1:0] AluAdd    = 2'b00;
    localparam logic [1:0] AluSub    = 2'b01;
    localparam logic [1:0] AluFunct  = 2'b10;

    // Raw per-state control word, before stall/branch/reset gating.
    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       mem_access;  // state waits on mem_ready_i
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       done;
    } ctrl_word_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the multi-cycle controller and the datapath.
// master: controller (samples instruction/status, drives control word).
// slave:  datapath (drives instruction/status, consumes control word).
interface multicycle_ctrl_fsm_if;
    logic [6:0] opcode_i;
    logic       funct3_0_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       PCWrite_o;
    logic       AdrSrc_o;
    logic       MemWrite_o;
    logic       IRWrite_o;
    logic [1:0] ResultSrc_o;
    logic [1:0] ALUSrcA_o;
    logic [1:0] ALUSrcB_o;
    logic [1:0] ALUOp_o;
    logic       RegWrite_o;
    logic       instr_done_o;
    logic       illegal_o;

    modport master (
        input  opcode_i, funct3_0_i, zero_i, mem_ready_i,
        output PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, ResultSrc_o, ALUSrcA_o,
               ALUSrcB_o, ALUOp_o, RegWrite_o, instr_done_o, illegal_o
    );

    modport slave (
        output opcode_i, funct3_0_i, zero_i, mem_ready_i,
        input  PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, ResultSrc_o, ALUSrcA_o,
               ALUSrcB_o, ALUOp_o, RegWrite_o, instr_done_o, illegal_o
    );
endinterface

// File: rtl/multicycle_ctrl_fsm_out_decode.sv
// ctrl_out_decode: purely combinational state -> raw control word decoder.
// Ports: state_i (current FSM state), ctrl_o (ungated control word).
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_e     state_i,
    output ctrl_word_t ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            StFetch: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.ir_write   = 1'b1;
                ctrl_o.mem_access = 1'b1;
                ctrl_o.alu_src_a  = SrcAPc;
                ctrl_o.alu_src_b  = SrcBFour;
                ctrl_o.alu_op     = AluAdd;
                ctrl_o.result_src = ResAluResult;
            end
            StDecode: begin
                ctrl_o.alu_src_a = SrcAOldPc;
                ctrl_o.alu_src_b = SrcBImm;
                ctrl_o.alu_op    = AluAdd;
            end
            StMemAdr: begin
                ctrl_o.alu_src_a = SrcARs1;
                ctrl_o.alu_src_b = SrcBImm;
                ctrl_o.alu_op    = AluAdd;
            end
            StMemRead: begin
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.mem_access = 1'b1;
            end
            StMemWb: begin
                ctrl_o.result_src = ResData;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.done       = 1'b1;
            end
            StMemWrite: begin
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.mem_access = 1'b1;
                ctrl_o.done       = 1'b1;
            end
            StExecR: begin
                ctrl_o.alu_src_a = SrcARs1;
                ctrl_o.alu_src_b = SrcBRs2;
                ctrl_o.alu_op    = AluFunct;
            end
            StExecI: begin
                ctrl_o.alu_src_a = SrcARs1;
                ctrl_o.alu_src_b = SrcBImm;
                ctrl_o.alu_op    = AluFunct;
            end
            StAluWb: begin
                ctrl_o.result_src = ResAluOut;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.done       = 1'b1;
            end
            StBranch: begin
                ctrl_o.branch     = 1'b1;
                ctrl_o.alu_src_a  = SrcARs1;
                ctrl_o.alu_src_b  = SrcBRs2;
                ctrl_o.alu_op     = AluSub;
                ctrl_o.result_src = ResAluOut;
                ctrl_o.done       = 1'b1;
            end
            StJal: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.alu_src_a  = SrcAOldPc;
                ctrl_o.alu_src_b  = SrcBFour;
                ctrl_o.result_src = ResAluOut;
            end
            StJalr: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.alu_src_a  = SrcARs1;
                ctrl_o.alu_src_b  = SrcBImm;
                ctrl_o.result_src = ResAluResult;
            end
            StLui: begin
                ctrl_o.result_src = ResImmExt;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.done       = 1'b1;
            end
            default: ;  // StTrap and unused codes: everything off
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: sequencing controller for the multi-cycle RV32I core.
// Ports: clk, rst_n (async active-low), bus (master modport: opcode/funct3[0]/zero/
// mem_ready in; PC/IR/mem/regfile enables, mux selects, ALUOp, instr_done, illegal out).
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_ctrl_fsm_if.master bus
);

    state_e     state_q, state_d;
    logic       illegal_q;
    ctrl_word_t ctrl;
    logic       stall;
    logic       taken;

    ctrl_out_decode u_decode (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:    if (bus.mem_ready_i) state_d = StDecode;
            StDecode: begin
                case (bus.opcode_i)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    OpLui:           state_d = StLui;
                    default:         state_d = StTrap;
                endcase
            end
            StMemAdr:   state_d = bus.opcode_i[5] ? StMemWrite : StMemRead;
            StMemRead:  if (bus.mem_ready_i) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (bus.mem_ready_i) state_d = StFetch;
            StExecR,
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            StJal,
            StJalr:     state_d = StAluWb;
            StLui:      state_d = StFetch;
            StTrap:     state_d = StTrap;
            default:    state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == StTrap) illegal_q <= 1'b1;
        end
    end

    assign stall = ctrl.mem_access & ~bus.mem_ready_i;
    // bne when funct3[0]=1, beq otherwise
    assign taken = ctrl.branch & (bus.zero_i ^ bus.funct3_0_i);

    // Write enables are gated by rst_n so an asserted reset kills them in the same cycle.
    assign bus.PCWrite_o    = rst_n & ((ctrl.pc_write & ~stall) | taken);
    assign bus.IRWrite_o    = rst_n & ctrl.ir_write & ~stall;
    assign bus.MemWrite_o   = rst_n & ctrl.mem_write;
    assign bus.RegWrite_o   = rst_n & ctrl.reg_write;
    assign bus.instr_done_o = rst_n & ctrl.done & ~stall;
    assign bus.AdrSrc_o     = ctrl.adr_src;
    assign bus.ResultSrc_o  = ctrl.result_src;
    assign bus.ALUSrcA_o    = ctrl.alu_src_a;
    assign bus.ALUSrcB_o    = ctrl.alu_src_b;
    assign bus.ALUOp_o      = ctrl.alu_op;
    assign bus.illegal_o    = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    multicycle_ctrl_fsm_if bus ();

    multicycle_ctrl_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
    //  RegWrite, instr_done, illegal}
    logic [15:0] obs;
    assign obs = {bus.PCWrite_o, bus.AdrSrc_o, bus.MemWrite_o, bus.IRWrite_o,
                  bus.ResultSrc_o, bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ALUOp_o,
                  bus.RegWrite_o, bus.instr_done_o, bus.illegal_o};

    function automatic logic [15:0] cw(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic rw,
                                       input logic dn, input logic il);
        return {pcw, adr, mw, irw, rs, a, b, op, rw, dn, il};
    endfunction

    task automatic check(input string tag, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %b want %b", tag, obs, exp);
    endtask

    // Compare on the falling edge, then advance to just past the next rising edge.
    task automatic tick(input string tag, input logic [15:0] exp);
        @(negedge clk);
        check(tag, exp);
        @(posedge clk);
        #1;
    endtask

    logic [15:0] w_rst, w_fetch, w_fstall, w_decode, w_execr, w_execi, w_aluwb;
    logic [15:0] w_memadr, w_memrd, w_memwb, w_memwr, w_memwr_done;
    logic [15:0] w_br_nt, w_br_t, w_jal, w_jalr, w_lui, w_trap;

    initial begin
        w_rst        = cw(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0);
        w_fetch      = cw(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0);
        w_fstall     = w_rst;
        w_decode     = cw(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0);
        w_execr      = cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0);
        w_execi      = cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0, 0);
        w_aluwb      = cw(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
        w_memadr     = cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0);
        w_memrd      = cw(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        w_memwb      = cw(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 1, 0);
        w_memwr      = cw(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        w_memwr_done = cw(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
        w_br_nt      = cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 1, 0);
        w_br_t       = cw(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 1, 0);
        w_jal        = cw(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0);
        w_jalr       = cw(1, 0, 0, 0, 2'b10, 2'b10, 2'b01, 2'b00, 0, 0, 0);
        w_lui        = cw(0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 1, 0);
        w_trap       = cw(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);

        rst_n           = 1'b1;
        bus.opcode_i    = 7'b0110011;
        bus.funct3_0_i  = 1'b0;
        bus.zero_i      = 1'b0;
        bus.mem_ready_i = 1'b1;  // ready during reset must not fire any enable
        #2 rst_n = 1'b0;
        tick("reset0", w_rst);
        tick("reset1", w_rst);
        rst_n = 1'b1;

        // add, zero wait states: 4 cycles
        tick("add_fetch", w_fetch);
        tick("add_decode", w_decode);
        tick("add_execr", w_execr);
        tick("add_aluwb", w_aluwb);

        // lw with two stalled fetch cycles: 7 cycles
        bus.opcode_i    = 7'b0000011;
        bus.mem_ready_i = 1'b0;
        tick("lw_fstall0", w_fstall);
        tick("lw_fstall1", w_fstall);
        bus.mem_ready_i = 1'b1;
        tick("lw_fetch", w_fetch);
        tick("lw_decode", w_decode);
        tick("lw_memadr", w_memadr);
        tick("lw_memread", w_memrd);
        tick("lw_memwb", w_memwb);

        // bne not taken (zero=1) then taken (zero=0)
        bus.opcode_i   = 7'b1100011;
        bus.funct3_0_i = 1'b1;
        bus.zero_i     = 1'b1;
        tick("bne_nt_fetch", w_fetch);
        tick("bne_nt_decode", w_decode);
        tick("bne_nt_branch", w_br_nt);
        bus.zero_i = 1'b0;
        tick("bne_t_fetch", w_fetch);
        tick("bne_t_decode", w_decode);
        tick("bne_t_branch", w_br_t);
        // beq taken
        bus.funct3_0_i = 1'b0;
        bus.zero_i     = 1'b1;
        tick("beq_fetch", w_fetch);
        tick("beq_decode", w_decode);
        tick("beq_branch", w_br_t);
        bus.zero_i = 1'b0;

        // sw with three stalled MEMWRITE cycles
        bus.opcode_i = 7'b0100011;
        tick("sw_fetch", w_fetch);
        tick("sw_decode", w_decode);
        tick("sw_memadr", w_memadr);
        bus.mem_ready_i = 1'b0;
        tick("sw_memwr0", w_memwr);
        tick("sw_memwr1", w_memwr);
        tick("sw_memwr2", w_memwr);
        bus.mem_ready_i = 1'b1;
        tick("sw_memwr_rdy", w_memwr_done);

        // jal, jalr, lui, addi
        bus.opcode_i = 7'b1101111;
        tick("jal_fetch", w_fetch);
        tick("jal_decode", w_decode);
        tick("jal_jal", w_jal);
        tick("jal_aluwb", w_aluwb);
        bus.opcode_i = 7'b1100111;
        tick("jalr_fetch", w_fetch);
        tick("jalr_decode", w_decode);
        tick("jalr_jalr", w_jalr);
        tick("jalr_aluwb", w_aluwb);
        bus.opcode_i = 7'b0110111;
        tick("lui_fetch", w_fetch);
        tick("lui_decode", w_decode);
        tick("lui_lui", w_lui);
        bus.opcode_i = 7'b0010011;
        tick("addi_fetch", w_fetch);
        tick("addi_decode", w_decode);
        tick("addi_execi", w_execi);
        tick("addi_aluwb", w_aluwb);

        // Reset asserted mid-MEMREAD, then restart at FETCH
        bus.opcode_i = 7'b0000011;
        tick("rmid_fetch", w_fetch);
        tick("rmid_decode", w_decode);
        tick("rmid_memadr", w_memadr);
        bus.mem_ready_i = 1'b0;
        tick("rmid_memread", w_memrd);
        #2;
        check("rmid_pre", w_memrd);
        bus.mem_ready_i = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rmid_async", w_rst);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick("rmid_fetch2", w_fetch);
        tick("rmid_decode2", w_decode);
        tick("rmid_memadr2", w_memadr);
        tick("rmid_memread2", w_memrd);
        tick("rmid_memwb2", w_memwb);

        // Illegal opcode: TRAP is sticky until reset
        bus.opcode_i = 7'b0000000;
        tick("ill_fetch", w_fetch);
        tick("ill_decode", w_decode);
        for (int i = 0; i < 22; i++) begin
            bus.mem_ready_i = i[0];
            bus.zero_i      = i[1];
            bus.funct3_0_i  = ~i[1];
            bus.opcode_i    = (i == 5) ? 7'b0110011 : 7'b0000000;
            tick($sformatf("ill_trap%0d", i), w_trap);
        end
        bus.mem_ready_i = 1'b1;
        bus.zero_i      = 1'b0;
        bus.funct3_0_i  = 1'b0;
        rst_n = 1'b0;
        #1;
        check("ill_reset", w_rst);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.opcode_i = 7'b0110011;
        tick("post_fetch", w_fetch);
        tick("post_decode", w_decode);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Sequencing controller for the multi-cycle RV32I core variant. It walks each instruction through fetch, decode, execute, memory and writeback states, and drives the shared ALU, memory port, instruction register, PC and register-file enables. It also stalls on a memory ready handshake and traps on unsupported opcodes. It sits beside the existing ALU decoder, which receives `ALUOp_o` from this block.

## Interface
- `OPCODE_WIDTH`, 7: width of opcode field taken from the instruction register.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode_i` in 7: `instr[6:0]` from the instruction register; valid from DECODE onward.
- `funct3_0_i` in 1: `instr[12]`; 0 = beq, 1 = bne.
- `zero_i` in 1: ALU zero flag.
- `mem_ready_i` in 1: memory completes the current access this cycle.
- `PCWrite_o` out 1: PC register enable.
- `AdrSrc_o` out 1: memory address source; 0 = PC, 1 = ALUOut.
- `MemWrite_o` out 1: memory write strobe.
- `IRWrite_o` out 1: instruction register and OldPC enable.
- `ResultSrc_o` out 2: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt.
- `ALUSrcA_o` out 2: 00 = PC, 01 = OldPC, 10 = rs1 register.
- `ALUSrcB_o` out 2: 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- `ALUOp_o` out 2: 00 = add, 01 = subtract/compare, 10 = decode funct.
- `RegWrite_o` out 1: register file write enable.
- `instr_done_o` out 1: one-cycle pulse on the final cycle of each instruction.
- `illegal_o` out 1: sticky flag for an unsupported opcode.

## Operation
- **Output style.** Moore FSM. All outputs decode from the current state, except the stall and branch gating below.
- **Fetch and memory states.** FETCH drives AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCWrite are asserted only when `mem_ready_i`=1. Otherwise the FSM stays in FETCH.
  - MEMREAD and MEMWRITE drive AdrSrc=1 and wait for `mem_ready_i` the same way.
  - MemWrite stays high for every MEMWRITE cycle.
- **DECODE.** Drives ALUSrcA=01, ALUSrcB=01, ALUOp=00, which precomputes the branch/jal target. Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - any other value → TRAP
- **MEMADR.** Drives ALUSrcA=10, ALUSrcB=01. Next state is MEMREAD if `opcode_i[5]`=0, else MEMWRITE.
- **Load and store completion.**
  - MEMREAD → MEMWB on ready.
  - MEMWB drives ResultSrc=01, RegWrite=1, then → FETCH.
  - MEMWRITE → FETCH on ready.
- **Execute states.**
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - Both → ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, then → FETCH.
- **BRANCH.** Drives ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, then → FETCH. PCWrite = `zero_i` XOR `funct3_0_i`.
- **Jumps.**
  - JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1, then → ALUWB. This writes OldPC+4 to rd.
  - JALR: same, except PC takes rs1+imm. It drives ALUSrcA=10, ALUSrcB=01, ResultSrc=10, PCWrite=1, then → ALUWB. The datapath captures OldPC+4 into ALUOut on the JALR cycle via its link path.
- **LUI.** Drives ResultSrc=11, RegWrite=1, then → FETCH.
- **TRAP.** Terminal. All enables 0, `illegal_o`=1. Exits only on reset.
- **instr_done_o** pulses in:
  - MEMWB
  - MEMWRITE with ready
  - ALUWB
  - BRANCH
  - LUI
- **Undriven fields.** Unlisted fields are 0 in each state.

## Timing
- **Reset.** While `rst_n`=0, state = FETCH and `illegal_o`=0.
  - PCWrite, IRWrite, MemWrite, RegWrite and `instr_done_o` are forced to 0 combinationally.
  - The mux selects show FETCH values.
  - Deasserting reset mid-instruction always restarts at FETCH. No partial writes are issued.
- **Cycles per instruction at zero wait-state.**
  - R/I-type: 4
  - lw: 5
  - sw: 4
  - beq/bne: 3
  - jal/jalr: 4
  - lui: 3
- **Wait states.** Each cycle with `mem_ready_i`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. No enable fires during a stall.
- **Ready pulses.** `mem_ready_i` asserted in a non-memory state is ignored.
- **Opcode sampling.** `opcode_i` is sampled only in DECODE and MEMADR; it is don't-care elsewhere.

## Structure
- `ctrl_pkg` holds:
  - the state enum (4-bit, 14 states)
  - opcode localparams
  - ResultSrc, ALUSrcA, ALUSrcB and ALUOp encodings

  The datapath muxes share these encodings.
- One sub-module, `ctrl_out_decode`: purely combinational state → control-word decoder. The top level holds the state register, next-state logic, stall gating, branch gating, reset gating and the sticky `illegal_o`.

## Test plan
- **R-type.** Reset release, then `add` (opcode 0110011) with `mem_ready_i`=1 throughout. Required: states FETCH, DECODE, EXECR, ALUWB; IRWrite in cycle 0; RegWrite and `instr_done_o` in cycle 3.
- **lw with a stalled fetch.** `lw` with `mem_ready_i` low for 2 FETCH cycles. Required: IRWrite and PCWrite stay 0 for 2 cycles, then fire; 7 cycles in total; RegWrite with ResultSrc=01 in MEMWB.
- **bne, both outcomes.** First with `zero_i`=1, then with `zero_i`=0, `funct3_0_i`=1 in both cases. Required: PCWrite=0, then PCWrite=1 in BRANCH; 3 cycles each.
- **sw with a memory stall.** `sw` with `mem_ready_i` low for 3 MEMWRITE cycles. Required: MemWrite high for 4 consecutive cycles; `instr_done_o` only on the ready cycle; RegWrite never asserted.
- **Illegal opcode.** Opcode 0000000. Required: TRAP after DECODE; `illegal_o` stays 1 and all enables stay 0 for 20+ cycles; the next `rst_n` pulse clears it.
- **Reset mid-instruction.** Assert `rst_n`=0 asynchronously in MEMREAD. Required: enables drop the same cycle; after release the FSM resumes at FETCH.
